// File: rtl/load_store_unit.sv
// MEM-stage data-memory initiator: aligns and issues one load/store, waits for ack
// or timeout, and returns extended load data or an exception with a single done pulse.
module load_store_unit #(
  parameter int MAX_WAIT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [2:0]  op,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        stall,
  output logic        done,
  output logic [31:0] load_data,
  output logic        exc_adel,
  output logic        exc_ades,
  output logic        bus_err,
  output logic [31:0] bad_vaddr,
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_t;

  state_t      state, state_nxt;
  logic [7:0]  cnt;
  logic [2:0]  op_p1;
  logic [31:0] addr_p1;
  logic        is_store, aligned, timeout;
  logic [3:0]  be_c;
  logic [31:0] wdata_c;

  // Pick the addressed lane out of the captured word and extend it for writeback.
  function automatic logic [31:0] extract(input logic [2:0] o, input logic [1:0] lane,
                                          input logic [31:0] word);
    logic [7:0]         b;
    logic [15:0]        h;
    logic signed [7:0]  bs;
    logic signed [15:0] hs;
    logic signed [31:0] r;
    b  = word[{lane, 3'b000} +: 8];
    h  = lane[1] ? word[31:16] : word[15:0];
    bs = $signed(b);
    hs = $signed(h);
    case (o)
      3'd0:    r = 32'(bs);
      3'd1:    r = $signed({24'd0, b});
      3'd2:    r = 32'(hs);
      3'd3:    r = $signed({16'd0, h});
      3'd4:    r = $signed(word);
      default: r = '0;
    endcase
    return r;
  endfunction

  always_comb begin
    is_store = (op >= 3'd5);
    aligned  = 1'b1;
    be_c     = 4'b0001 << addr[1:0];
    wdata_c  = {4{store_data[7:0]}};
    case (op)
      3'd2, 3'd3, 3'd6: begin
        aligned = ~addr[0];
        be_c    = addr[1] ? 4'b1100 : 4'b0011;
        wdata_c = {2{store_data[15:0]}};
      end
      3'd4, 3'd7: begin
        aligned = (addr[1:0] == 2'b00);
        be_c    = 4'b1111;
        wdata_c = store_data;
      end
      default: ;
    endcase
    if (!is_store) wdata_c = '0;
  end

  assign timeout = (cnt == 8'(MAX_WAIT));

  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    case (state)
      IDLE: begin
        stall = req_valid & aligned;
        if (req_valid) state_nxt = aligned ? WAIT : RESP;
      end
      WAIT: begin
        stall = 1'b1;
        if (mem_ack || timeout) state_nxt = RESP;
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      op_p1     <= '0;
      addr_p1   <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_be    <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      done      <= 1'b0;
      load_data <= '0;
      exc_adel  <= 1'b0;
      exc_ades  <= 1'b0;
      bus_err   <= 1'b0;
      bad_vaddr <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        // IDLE -> issue on the bus, or fault straight into RESP
        IDLE: begin
          if (req_valid && aligned) begin
            mem_req   <= 1'b1;
            mem_we    <= is_store;
            mem_be    <= be_c;
            mem_addr  <= {addr[31:2], 2'b00};
            mem_wdata <= wdata_c;
            op_p1     <= op;
            addr_p1   <= addr;
            cnt       <= '0;
          end else if (req_valid) begin
            done      <= 1'b1;
            load_data <= '0;
            exc_adel  <= ~is_store;
            exc_ades  <= is_store;
            bad_vaddr <= addr;
          end
        end
        // WAIT -> an ack on the final allowed edge still wins over the timeout
        WAIT: begin
          if (mem_ack) begin
            mem_req   <= 1'b0;
            done      <= 1'b1;
            load_data <= (op_p1 >= 3'd5) ? 32'd0 : extract(op_p1, addr_p1[1:0], mem_rdata);
          end else if (timeout) begin
            mem_req   <= 1'b0;
            done      <= 1'b1;
            bus_err   <= 1'b1;
            load_data <= '0;
            bad_vaddr <= addr_p1;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        // RESP -> result fields live for this one cycle only
        RESP: begin
          done      <= 1'b0;
          load_data <= '0;
          exc_adel  <= 1'b0;
          exc_ades  <= 1'b0;
          bus_err   <= 1'b0;
          bad_vaddr <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

MEM-stage bus initiator: the requesting end of the data-memory interface. Accepts one load/store per instruction from the EX/MEM register, checks alignment, drives a word-addressed request with byte enables to the data memory, and waits a variable number of cycles for the acknowledge. On acknowledge it returns sign- or zero-extended load data to writeback; on timeout it returns a bus error. The pipeline is stalled while a request is outstanding.

## Interface

Parameters:
- MAX_WAIT, 16: wait-state cycles allowed before declaring a bus error (1..255).

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- req_valid  in  1  memory op present in EX/MEM; held with its operands while stall=1
- op  in  3  0 LB, 1 LBU, 2 LH, 3 LHU, 4 LW, 5 SB, 6 SH, 7 SW
- addr  in  32  byte virtual address (ALU result)
- store_data  in  32  store operand, rt value
- stall  out  1  freeze IF..MEM
- done  out  1  one-cycle completion pulse; the result fields below are valid only while done=1
- load_data  out  32  extended load result; 0 for stores, errors, and timeouts
- exc_adel  out  1  misaligned load
- exc_ades  out  1  misaligned store
- bus_err  out  1  ack timeout
- bad_vaddr  out  32  faulting address when exc_adel, exc_ades, or bus_err is set; else 0
- mem_req  out  1  request strobe, registered
- mem_we  out  1  1 store, 0 load
- mem_be  out  4  byte enables, bit i = byte lane i, little-endian
- mem_addr  out  32  {addr[31:2],2'b00}
- mem_wdata  out  32  lane-replicated store data
- mem_ack  in  1  responder completion; mem_rdata is valid with it
- mem_rdata  in  32  read word

## Operation

- States: IDLE, WAIT, RESP.
- **IDLE**
  - With req_valid=1 and an aligned op: register the bus fields, set mem_req=1, clear the wait counter, go to WAIT.
  - With req_valid=1 and a misaligned op: no bus access; latch the exception and addr, go to RESP.
- **Alignment**
  - LH, LHU, SH require addr[0]=0.
  - LW, SW require addr[1:0]=0.
  - Byte ops never fault.
- **Enables and write data**
  - Byte ops: mem_be = 1<<addr[1:0]; mem_wdata = {4{store_data[7:0]}}.
  - Half ops: mem_be = addr[1] ? 1100 : 0011; mem_wdata = {2{store_data[15:0]}}.
  - Word ops: mem_be = 1111; mem_wdata = store_data.
  - Loads drive mem_be the same way with mem_we=0; mem_wdata = 0.
- **WAIT**
  - All mem_* outputs stay constant.
  - On a clock edge with mem_ack=1: drop mem_req, capture mem_rdata, go to RESP.
  - Otherwise increment the 8-bit counter. When the counter reaches MAX_WAIT with no ack: drop mem_req, set bus_err, go to RESP.
  - An ack arriving on the same edge the counter reaches MAX_WAIT counts as success.
- **Load extraction** from the captured word:
  - Byte lane addr[1:0]; half lane addr[1].
  - LB, LH sign-extend; LBU, LHU zero-extend; LW passes the word through.
- **RESP**
  - done=1 for exactly one cycle, with the result fields set.
  - Next state is IDLE unconditionally. req_valid is ignored in RESP because it still reflects the completing instruction.
- **stall** (combinational) = (IDLE & req_valid & aligned) | WAIT.
  - stall is 0 in RESP, so the pipeline advances on that edge.
  - A misaligned op in IDLE does not raise stall.
- mem_ack outside WAIT is ignored.

## Timing

- Reset (async):
  - state IDLE.
  - mem_req, mem_we, mem_be, mem_addr, mem_wdata all 0.
  - done, load_data, exceptions, bus_err, bad_vaddr all 0.
  - counter 0.
- Reset mid-WAIT: mem_req drops immediately and the transaction is abandoned with no done pulse.
- Zero-wait ack, accepted at edge T0:
  - mem_req high during T0→T1, ack sampled at T1.
  - done during T1→T2.
  - stall is high from the cycle of acceptance until T1.
- Each wait state adds one cycle.
- Misaligned op: accepted at T0, done during T0→T1.
- Timeout: mem_req high for exactly MAX_WAIT+1 cycles, then done with bus_err.
- Back-to-back ops: minimum spacing is 3 cycles (IDLE→WAIT→RESP).

## Test plan

- LW addr 0x0000_0010, ack after 0 waits, rdata 0xDEADBEEF -> mem_addr 0x10, be 1111, we 0; done one cycle later with load_data 0xDEADBEEF; stall high exactly 2 cycles.
- LB addr 0x13, rdata 0x80FF_0000 -> be 1000, load_data 0xFFFF_FF80. LBU at the same address -> 0x0000_0080. LH addr 0x12 with rdata 0x80FF_0000 -> 0xFFFF_80FF.
- SH addr 0x22, store_data 0x1234_ABCD, 3 wait states -> mem_addr 0x20, be 1100, wdata 0xABCD_ABCD, we 1, all held stable 4 cycles; done with load_data 0.
- LW addr 0x6 -> no mem_req; done with exc_adel=1, bad_vaddr 0x6. SW addr 0x1 -> exc_ades=1.
- Load with no ack, MAX_WAIT=16 -> mem_req high 17 cycles, then done, bus_err=1, bad_vaddr = addr, load_data 0. Ack on the 17th cycle -> normal completion.
- Assert reset during WAIT -> mem_req 0 immediately, no done; a following LW completes normally.
